// File: rtl/key_scan.sv
// 4x4 matrix keypad scanner: walks active-low rows, samples synchronized columns,
// and debounces whole-frame results into a press strobe, held flag and display digit.
module key_scan #(
    parameter int SCAN_DIV   = 1000,
    parameter int DEB_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] key_row,
    input  logic [3:0] key_col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down,
    output logic [2:0] num
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEB_FRAMES + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEB_FRAMES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PRESS_CHK = 2'd1,
        S_HELD      = 2'd2,
        S_REL_CHK   = 2'd3
    } state_t;

    // Column synchronizer; idle (pulled-up) value is all ones.
    logic [3:0] col_m_q, col_s_q;

    logic [DW-1:0] div_q, div_d;
    logic [1:0]    row_q, row_d;
    logic [3:0]    row_drv_q, row_drv_d;

    logic          hit_vld_q, hit_vld_d;
    logic [3:0]    hit_code_q, hit_code_d;

    state_t        state_q, state_d;
    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    code_q, code_d;
    logic          valid_q, valid_d;
    logic          down_q, down_d;
    logic [2:0]    num_q, num_d;

    logic          sample, frame_end, col_hit;
    logic [1:0]    col_idx;
    logic          frame_has;
    logic [3:0]    frame_code;
    logic [CW-1:0] cnt_inc;

    assign sample    = (div_q == DIV_LAST);
    assign frame_end = sample && (row_q == 2'd3);
    assign col_hit   = (col_s_q != 4'b1111);
    assign cnt_inc   = cnt_q + CNT_ONE;

    // Lowest-numbered active-low column wins.
    always_comb begin
        col_idx = 2'd0;
        if (!col_s_q[0])      col_idx = 2'd0;
        else if (!col_s_q[1]) col_idx = 2'd1;
        else if (!col_s_q[2]) col_idx = 2'd2;
        else if (!col_s_q[3]) col_idx = 2'd3;
    end

    // Frame result folds in the row-3 sample taken on the frame-end cycle itself.
    always_comb begin
        frame_has  = hit_vld_q || (sample && col_hit);
        frame_code = hit_vld_q ? hit_code_q : {row_q, col_idx};
    end

    always_comb begin
        div_d      = sample ? '0 : div_q + 1'b1;
        row_d      = sample ? row_q + 2'd1 : row_q;
        row_drv_d  = 4'b1111;
        row_drv_d[row_d] = 1'b0;
        hit_vld_d  = hit_vld_q;
        hit_code_d = hit_code_q;
        if (frame_end) begin
            hit_vld_d  = 1'b0;
            hit_code_d = 4'd0;
        end else if (sample && col_hit && !hit_vld_q) begin
            hit_vld_d  = 1'b1;
            hit_code_d = {row_q, col_idx};
        end
    end

    // Debounce FSM; only advances on frame boundaries.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        valid_d = 1'b0;
        down_d  = down_q;
        num_d   = num_q;
        if (frame_end) begin
            case (state_q)
                S_IDLE: begin
                    if (frame_has) begin
                        state_d = S_PRESS_CHK;
                        cand_d  = frame_code;
                        cnt_d   = CNT_ONE;
                    end
                end
                S_PRESS_CHK: begin
                    if (!frame_has) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (frame_code == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            state_d = S_HELD;
                            code_d  = cand_q;
                            valid_d = 1'b1;
                            down_d  = 1'b1;
                            if (cand_q < 4'd6) num_d = cand_q[2:0];
                        end
                    end else begin
                        cand_d = frame_code;
                        cnt_d  = CNT_ONE;
                    end
                end
                S_HELD: begin
                    if (!frame_has) begin
                        state_d = S_REL_CHK;
                        cnt_d   = CNT_ONE;
                    end
                end
                S_REL_CHK: begin
                    if (frame_has) begin
                        state_d = S_HELD;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            state_d = S_IDLE;
                            down_d  = 1'b0;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_m_q    <= 4'b1111;
            col_s_q    <= 4'b1111;
            div_q      <= '0;
            row_q      <= 2'd0;
            row_drv_q  <= 4'b1110;
            hit_vld_q  <= 1'b0;
            hit_code_q <= 4'd0;
            state_q    <= S_IDLE;
            cand_q     <= 4'd0;
            cnt_q      <= '0;
            code_q     <= 4'd0;
            valid_q    <= 1'b0;
            down_q     <= 1'b0;
            num_q      <= 3'd0;
        end else begin
            col_m_q    <= key_col;
            col_s_q    <= col_m_q;
            div_q      <= div_d;
            row_q      <= row_d;
            row_drv_q  <= row_drv_d;
            hit_vld_q  <= hit_vld_d;
            hit_code_q <= hit_code_d;
            state_q    <= state_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            down_q     <= down_d;
            num_q      <= num_d;
        end
    end

    assign key_row   = row_drv_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_down  = down_q;
    assign num       = num_q;

endmodule

// File: tb/tb_key_scan.sv
// Self-checking bench for key_scan: a keypad matrix model drives the columns,
// accepted-press events go through an expected/observed scoreboard.
module tb_key_scan;

    localparam int SD = 4;
    localparam int DF = 3;
    localparam int FR = 4 * SD;

    typedef struct packed {
        logic [3:0] code;
        logic [2:0] num;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_row, key_col, key_code;
    logic       key_valid, key_down;
    logic [2:0] num;
    logic [15:0] pressed = '0;

    ev_t exp_q[$];
    ev_t obs_q[$];
    logic [2:0] exp_num = 3'd0;
    int  pass_cnt = 0;
    int  chk_cnt  = 0;
    int  dbl_cnt  = 0;
    logic prev_valid = 1'b0;

    key_scan #(.SCAN_DIV(SD), .DEB_FRAMES(DF)) dut (
        .clk(clk), .rst(rst), .key_row(key_row), .key_col(key_col),
        .key_code(key_code), .key_valid(key_valid), .key_down(key_down), .num(num)
    );

    always #5 clk = ~clk;

    // Passive matrix: a pressed key pulls its column low while its row is driven.
    always_comb begin
        key_col = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !key_row[r]) key_col[c] = 1'b0;
    end

    always @(negedge clk) begin
        if (!rst && key_valid) obs_q.push_back('{code: key_code, num: num});
        if (!rst && key_valid && prev_valid) dbl_cnt++;
        prev_valid <= key_valid & ~rst;
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push_exp(input logic [3:0] c);
        ev_t e;
        if (c < 4'd6) exp_num = c[2:0];
        e.code = c;
        e.num  = exp_num;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        exp_num = 3'd0;
    endtask

    task automatic test_reset();
        logic [3:0] er;
        pressed = '0;
        tick(2);
        chk_cnt++;
        if ({key_row, key_code, key_valid, key_down, num} !== {4'b1110, 4'd0, 1'b0, 1'b0, 3'd0})
            $display("FAIL reset_vals: got row=%b code=%0d v=%b d=%b num=%0d", key_row, key_code, key_valid, key_down, num);
        else pass_cnt++;
        rst = 1'b0;
        for (int k = 0; k <= FR; k++) begin
            er = 4'b1111;
            er[(k / SD) % 4] = 1'b0;
            chk_cnt++;
            if (key_row !== er) $display("FAIL row_seq[%0d]: got %b want %b", k, key_row, er);
            else pass_cnt++;
            tick(1);
        end
        tick(4 * FR - 1);
        chk_cnt++;
        if (obs_q.size() !== 0 || key_down !== 1'b0 || key_code !== 4'd0 || num !== 3'd0)
            $display("FAIL idle_quiet: pulses=%0d down=%b code=%0d num=%0d want 0", obs_q.size(), key_down, key_code, num);
        else pass_cnt++;
    endtask

    task automatic test_single_press();
        ev_t e, o;
        do_reset();
        pressed = 16'h0010;
        push_exp(4'd4);
        tick(3 * FR - 1);
        chk_cnt++;
        if (key_valid !== 1'b0 || obs_q.size() !== 0) $display("FAIL early_valid: got pulses=%0d want 0", obs_q.size());
        else pass_cnt++;
        tick(1);
        chk_cnt++;
        if ({key_valid, key_code, num, key_down} !== {1'b1, 4'd4, 3'd4, 1'b1})
            $display("FAIL accept_r1c0: got v=%b code=%0d num=%0d d=%b want 1/4/4/1", key_valid, key_code, num, key_down);
        else pass_cnt++;
        pressed = '0;
        tick(3 * FR - 1);
        chk_cnt++;
        if (key_down !== 1'b1) $display("FAIL down_hold: got %b want 1", key_down);
        else pass_cnt++;
        tick(1);
        chk_cnt++;
        if (key_down !== 1'b0) $display("FAIL down_release: got %b want 0", key_down);
        else pass_cnt++;
        chk_cnt++;
        if (obs_q.size() !== 1) $display("FAIL sb_count_single: got %0d want 1", obs_q.size());
        else pass_cnt++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            chk_cnt++;
            if (o !== e) $display("FAIL sb_single: got code=%0d num=%0d want code=%0d num=%0d", o.code, o.num, e.code, e.num);
            else pass_cnt++;
        end
    endtask

    task automatic test_no_num();
        ev_t e, o;
        pressed = 16'h0040;
        push_exp(4'd6);
        tick(4 * FR);
        chk_cnt++;
        if ({key_code, num, key_down} !== {4'd6, 3'd4, 1'b1})
            $display("FAIL code6: got code=%0d num=%0d d=%b want 6/4/1", key_code, num, key_down);
        else pass_cnt++;
        chk_cnt++;
        if (obs_q.size() !== 1) $display("FAIL sb_count_code6: got %0d want 1", obs_q.size());
        else pass_cnt++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            chk_cnt++;
            if (o !== e) $display("FAIL sb_code6: got code=%0d num=%0d want code=%0d num=%0d", o.code, o.num, e.code, e.num);
            else pass_cnt++;
        end
        pressed = '0;
        tick(3 * FR);
        chk_cnt++;
        if (key_down !== 1'b0) $display("FAIL release6: got %b want 0", key_down);
        else pass_cnt++;
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 8; i++) begin
            pressed = 16'h0010;
            tick(FR);
            pressed = '0;
            tick(FR);
            chk_cnt++;
            if (key_down !== 1'b0) $display("FAIL bounce_down[%0d]: got %b want 0", i, key_down);
            else pass_cnt++;
        end
        chk_cnt++;
        if (obs_q.size() !== 0) $display("FAIL bounce_pulses: got %0d want 0", obs_q.size());
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        ev_t e, o;
        pressed = 16'h0010;
        push_exp(4'd4);
        tick(10 * FR);
        pressed = '0;
        tick(FR);
        pressed = 16'h0010;
        tick(3 * FR);
        chk_cnt++;
        if (obs_q.size() !== 1 || key_down !== 1'b1)
            $display("FAIL glitch_release: got pulses=%0d down=%b want 1/1", obs_q.size(), key_down);
        else pass_cnt++;
        pressed = '0;
        tick(3 * FR);
        chk_cnt++;
        if (key_down !== 1'b0) $display("FAIL b2b_release: got %b want 0", key_down);
        else pass_cnt++;
        pressed = 16'h0010;
        push_exp(4'd4);
        tick(3 * FR);
        chk_cnt++;
        if (key_valid !== 1'b1) $display("FAIL b2b_second: got %b want 1", key_valid);
        else pass_cnt++;
        tick(FR);
        chk_cnt++;
        if (obs_q.size() !== 2) $display("FAIL sb_count_b2b: got %0d want 2", obs_q.size());
        else pass_cnt++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            chk_cnt++;
            if (o !== e) $display("FAIL sb_b2b: got code=%0d num=%0d want code=%0d num=%0d", o.code, o.num, e.code, e.num);
            else pass_cnt++;
        end
        pressed = '0;
        tick(3 * FR);
    endtask

    task automatic test_multi_reset();
        ev_t e, o;
        pressed = 16'h0208;
        push_exp(4'd3);
        tick(4 * FR);
        chk_cnt++;
        if (obs_q.size() !== 1) $display("FAIL sb_count_multi: got %0d want 1", obs_q.size());
        else pass_cnt++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            chk_cnt++;
            if (o !== e) $display("FAIL sb_multi: got code=%0d num=%0d want code=%0d num=%0d", o.code, o.num, e.code, e.num);
            else pass_cnt++;
        end
        pressed = '0;
        tick(3 * FR);
        pressed = 16'h0020;
        tick(2 * FR + 5);
        rst = 1'b1;
        tick(1);
        chk_cnt++;
        if ({key_row, key_code, key_valid, key_down, num} !== {4'b1110, 4'd0, 1'b0, 1'b0, 3'd0})
            $display("FAIL midreset: got row=%b code=%0d v=%b d=%b num=%0d", key_row, key_code, key_valid, key_down, num);
        else pass_cnt++;
        tick(1);
        rst = 1'b0;
        exp_num = 3'd0;
        push_exp(4'd5);
        tick(3 * FR - 1);
        chk_cnt++;
        if (key_valid !== 1'b0 || obs_q.size() !== 0) $display("FAIL reset_count_kept: got pulses=%0d want 0", obs_q.size());
        else pass_cnt++;
        tick(1);
        chk_cnt++;
        if ({key_valid, key_code, num} !== {1'b1, 4'd5, 3'd5})
            $display("FAIL post_reset_accept: got v=%b code=%0d num=%0d want 1/5/5", key_valid, key_code, num);
        else pass_cnt++;
        tick(FR);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            chk_cnt++;
            if (o !== e) $display("FAIL sb_post_reset: got code=%0d num=%0d want code=%0d num=%0d", o.code, o.num, e.code, e.num);
            else pass_cnt++;
        end
        chk_cnt++;
        if (exp_q.size() !== 0 || obs_q.size() !== 0 || dbl_cnt !== 0)
            $display("FAIL sb_drain: got exp=%0d obs=%0d double=%0d want 0/0/0", exp_q.size(), obs_q.size(), dbl_cnt);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_no_num();
        test_bounce();
        test_back_to_back();
        test_multi_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/key_scan.md
# key_scan

4x4 matrix keypad scanner, the input-side counterpart of the dot-matrix display driver. It drives keypad rows one at a time, samples the column lines, and debounces over whole scan frames. Each accepted press produces a one-cycle strobe and a 4-bit key code. It also holds a 3-bit `num` register that feeds the display driver's digit input directly.

## Interface
- `SCAN_DIV`, default 1000: clk cycles each row is driven; legal range ≥ 4.
- `DEB_FRAMES`, default 4: consecutive identical frame results needed to accept a press or a release; legal range ≥ 2.

- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `key_row`  out  4  row drive, active-low one-hot; bit r is low while row r is selected.
- `key_col`  in  4  column sense, active-low (pulled up); asynchronous to `clk`.
- `key_code`  out  4  last accepted key, encoded row*4+col.
- `key_valid`  out  1  one-cycle pulse when a press is accepted.
- `key_down`  out  1  high while the accepted key is held, until the release is confirmed.
- `num`  out  3  last accepted key_code if it is < 6, otherwise unchanged; feeds the display.

## Operation
- `key_col` passes through a 2-flop synchronizer; the synchronized value is `col_s`.
- `div_cnt` counts 0..SCAN_DIV-1. The sample point is `div_cnt == SCAN_DIV-1`. At that point `row_idx` advances 0→1→2→3→0 and `key_row` updates.
- At each sample, if `col_s != 4'b1111` and no hit has been recorded yet this frame, record `hit_code = {row_idx, index of lowest-numbered low col bit}`.
  - Priority: lowest row first, then lowest column.
- The frame ends at the row-3 sample. Its result is either NONE or `hit_code`. Hit storage is cleared for the next frame.
- Debounce FSM, evaluated once per frame end, with a candidate register `cand` and frame counter `cnt`:
  - IDLE: code c → PRESS_CHK, cand=c, cnt=1. NONE → stay.
  - PRESS_CHK:
    - Same code → cnt+1. When cnt reaches DEB_FRAMES, accept: key_code=cand, pulse key_valid, key_down=1, num=cand[2:0] if cand<6, go to HELD.
    - Different code → cand=new, cnt=1.
    - NONE → IDLE.
  - HELD: any code → stay, with no auto-repeat; changing keys while held is ignored. NONE → RELEASE_CHK, cnt=1.
  - RELEASE_CHK: NONE → cnt+1; at DEB_FRAMES → IDLE, key_down=0. Any code → HELD.
- Reset values:
  - div_cnt=0, row_idx=0, key_row=4'b1110.
  - Synchronizer flops = 4'b1111.
  - state=IDLE, cand=0, cnt=0, hit storage cleared.
  - key_code=0, key_valid=0, key_down=0, num=0.
- Reset asserted mid-operation returns everything to the reset values on the next clk edge. An in-progress debounce count is discarded.

## Timing
- All outputs are registered.
- `key_row` changes on the edge after each sample point, so every row is stable for SCAN_DIV cycles.
- Settle margin before sampling is SCAN_DIV-3 cycles, after allowing 2 synchronizer cycles and 1 row-register cycle.
- One frame = 4*SCAN_DIV cycles.
- `key_valid`, `key_code`, `key_down` and `num` all update on the same edge, the edge following the frame-end sample that completes DEB_FRAMES.
- Worst-case press-to-`key_valid` latency for a stable press is (DEB_FRAMES+1)*4*SCAN_DIV + 3 cycles.
- `key_valid` never asserts on two consecutive cycles. At most one pulse per accepted press.
- The counters wrap naturally: `div_cnt` goes SCAN_DIV-1→0 and `row_idx` goes 3→0, with no idle gap between frames.

## Test plan
All scenarios use SCAN_DIV=4 and DEB_FRAMES=3, so one frame is 16 cycles.
- Reset, then no keys pressed → key_row=1110 for 4 cycles, then 1101, 1011, 0111, back to 1110 at cycle 16. All other outputs stay 0 and key_valid never pulses.
- Row1 col0 held low whenever key_row[1]=0, stable → exactly one key_valid pulse after the 3rd full frame; key_code=4, num=4, key_down=1.
- Row1 col2 pressed and held → key_code=6, num keeps its previous value, key_valid pulses once. Release for 3 frames → key_down=0.
- Bounce: key present 1 frame, absent 1 frame, repeated 8 times → no key_valid pulse and key_down stays 0.
- Held for 10 frames, released 1 frame, pressed again → no second pulse. Then released 3 frames and pressed 3 frames → second pulse.
- Row0 col3 and row2 col1 pressed together → key_code=3. Then reset asserted during PRESS_CHK of a new key → all reset values restored; acceptance afterwards needs a full 3 frames again.
